mmio_requester: RTL

- Initiator side of the CCI-P-style MMIO channel. Accepts host-side commands (read or write, 16-bit word address, 64-bit data) and drives one-cycle MMIO write/read request strobes toward an MMIO responder AFU.
- For reads: tags each request with a 9-bit TID, matches the returned TID, and reports data or timeout to the command source.
- Used as a synthesizable host model for loopback self-test of MMIO responders, and as the MMIO master in the simulation harness.

---
 rtl/mmio_requester.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mmio_requester.sv
// mmio_requester: initiator side of an MMIO request/response channel.
// Accepts one host command at a time, issues a single-cycle write or read
// strobe toward the responder, tags reads with a rolling 9-bit TID, waits
// for the matching response (or gives up after a bounded wait) and reports
// each completion with a one-cycle result pulse.
module mmio_requester #(
   parameter int          TIMEOUT_CYCLES = 256,
   parameter logic [8:0]  TID_INIT       = 9'h000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [15:0] cmd_addr,
   input  logic [63:0] cmd_wdata,
   output logic        mmio_wr_valid,
   output logic        mmio_rd_valid,
   output logic [15:0] req_addr,
   output logic [8:0]  req_tid,
   output logic [63:0] req_data,
   input  logic        rsp_valid,
   input  logic [8:0]  rsp_tid,
   input  logic [63:0] rsp_data,
   output logic        res_valid,
   output logic [63:0] res_data,
   output logic        res_timeout,
   output logic        res_error,
   output logic [7:0]  stray_cnt
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_ISSUE    = 2'd1;
   localparam logic [1:0] S_WAIT_RSP = 2'd2;
   localparam logic [1:0] S_DONE     = 2'd3;

   // The wait ends when the incremented count reaches this value, so a read
   // spends TIMEOUT_CYCLES-1 cycles in WAIT_RSP and its timeout result
   // appears TIMEOUT_CYCLES cycles after the read strobe.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state;
   logic        write_q;
   logic [8:0]  tid_q;
   logic [15:0] to_cnt;
   logic [15:0] to_cnt_nxt;
   logic        rsp_match;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign cmd_ready  = (state == S_IDLE);
   assign to_cnt_nxt = to_cnt + 16'd1;
   // req_tid holds the issued TID for the whole wait, so it doubles as the
   // match reference.
   assign rsp_match  = rsp_valid && (rsp_tid == req_tid);

   // Command FSM; drives every registered request and result output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         write_q       <= 1'b0;
         tid_q         <= TID_INIT;
         to_cnt        <= 16'd0;
         mmio_wr_valid <= 1'b0;
         mmio_rd_valid <= 1'b0;
         req_addr      <= 16'd0;
         req_tid       <= 9'd0;
         req_data      <= 64'd0;
         res_valid     <= 1'b0;
         res_data      <= 64'd0;
         res_timeout   <= 1'b0;
         res_error     <= 1'b0;
      end else begin
         mmio_wr_valid <= 1'b0;
         mmio_rd_valid <= 1'b0;
         res_valid     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  write_q  <= cmd_write;
                  req_addr <= cmd_addr;
                  req_data <= cmd_wdata;
                  if (cmd_addr[0]) begin
                     // Misaligned 64-bit access: report the error, never strobe.
                     state     <= S_DONE;
                     res_valid <= 1'b1;
                     res_error <= 1'b1;
                     res_data  <= 64'd0;
                  end else begin
                     state         <= S_ISSUE;
                     mmio_wr_valid <= cmd_write;
                     mmio_rd_valid <= ~cmd_write;
                     req_tid       <= tid_q;
                  end
               end
            end
            S_ISSUE: begin
               if (write_q) begin
                  state     <= S_DONE;
                  res_valid <= 1'b1;
                  res_data  <= 64'd0;
               end else begin
                  state  <= S_WAIT_RSP;
                  to_cnt <= 16'd0;
                  tid_q  <= tid_q + 9'd1;
               end
            end
            S_WAIT_RSP: begin
               if (rsp_match) begin
                  // A match in the final timeout cycle still completes normally.
                  state     <= S_DONE;
                  res_valid <= 1'b1;
                  res_data  <= rsp_data;
               end else if (to_cnt_nxt == TO_LAST) begin
                  state       <= S_DONE;
                  res_valid   <= 1'b1;
                  res_timeout <= 1'b1;
                  res_data    <= 64'd0;
               end else begin
                  to_cnt <= to_cnt_nxt;
               end
            end
            S_DONE: begin
               state       <= S_IDLE;
               res_data    <= 64'd0;
               res_timeout <= 1'b0;
               res_error   <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Count responses that arrive outside a wait or carry the wrong TID.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stray_cnt <= 8'd0;
      end else if (rsp_valid && !((state == S_WAIT_RSP) && rsp_match)) begin
         stray_cnt <= sat_inc8(stray_cnt);
      end
   end

endmodule
